im2col_window_ctrl: RTL

- Parametrised K x K sliding-window builder for the img2col path.
- Accepts one image column of K pixels per handshake and holds the last K columns in a shift register. Emits a full K*K window each time STRIDE new columns have arrived; after the first window, the K-STRIDE overlapping columns are reused rather than refetched.
- Processes one row-band of cfg_img_w columns per start. Sits between the column fetch stage and the PE array window input.

---
 rtl/im2col_pkg.sv | 23 ++
 rtl/im2col_col_shreg.sv | 29 ++
 rtl/im2col_window_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/im2col_pkg.sv
// Shared types and defaults for the img2col K x K sliding-window controller.
package im2col_pkg;

  localparam int DW_DEF    = 16;
  localparam int K_DEF     = 5;
  localparam int MAX_W_DEF = 64;
  localparam int STRIDE_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    EMIT,
    SLIDE,
    DRAIN
  } state_t;

  // Windows produced by one row-band of w columns; 0 for an unusable configuration.
  function automatic int num_windows(input int w, input int k, input int s);
    if (w < k || s < 1) return 0;
    return (w - k) / s + 1;
  endfunction

endpackage

// File: rtl/im2col_col_shreg.sv
// K-column shift register: each shift moves every column one place older and
// loads the incoming column as the newest (column K-1).
module im2col_col_shreg #(
  parameter int DW = 16,
  parameter int K  = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              shift_en,
  input  logic [K*DW-1:0]   col_data,
  output logic [K*K*DW-1:0] win_data
);

  // NOTE: the window store is reset because a restarted band must never expose
  // pixels left over from an aborted one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      win_data <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_data[(r*K+c)*DW +: DW] <= win_data[(r*K+c+1)*DW +: DW];
        end
        win_data[(r*K+K-1)*DW +: DW] <= col_data[r*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/im2col_window_ctrl.sv
// Sliding-window builder: collects image columns, emits a K x K window every
// STRIDE columns and reuses the overlapping columns between windows.
module im2col_window_ctrl
  import im2col_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int K     = K_DEF,
  parameter int MAX_W = MAX_W_DEF,
  parameter int CW    = $clog2(MAX_W + 1)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [CW-1:0]       cfg_img_w,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic                col_valid,
  output logic                col_ready,
  input  logic [K*DW-1:0]     col_data,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [K*K*DW-1:0]   win_data,
  output logic                win_last,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  state_t              state;
  logic [CW-1:0]       img_w;
  logic [CW-1:0]       col_cnt;
  logic [STRIDE_W-1:0] stride;
  logic [STRIDE_W-1:0] skip_cnt;

  logic          col_acc;
  logic [CW-1:0] cnt_inc;
  logic          last_next;
  logic          cfg_ok;

  assign col_acc = col_valid && col_ready;
  assign cnt_inc = col_cnt + CW'(1);
  // The window formed by this accept is the last one if another stride would overrun the band.
  assign last_next = ({2'b00, cnt_inc} + {{CW{1'b0}}, stride}) > {2'b00, img_w};
  assign cfg_ok = (cfg_img_w >= CW'(K)) && (cfg_img_w <= CW'(MAX_W)) &&
                  (cfg_stride != '0);
  assign busy = (state != IDLE);

  im2col_col_shreg #(
    .DW(DW),
    .K (K)
  ) u_shreg (
    .clk     (clk),
    .nrst    (nrst),
    .shift_en(col_acc),
    .col_data(col_data),
    .win_data(win_data)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      img_w     <= '0;
      stride    <= '0;
      col_cnt   <= '0;
      skip_cnt  <= '0;
      col_ready <= 1'b0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              img_w     <= cfg_img_w;
              stride    <= cfg_stride;
              col_cnt   <= '0;
              col_ready <= 1'b1;
              state     <= FILL;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        FILL: begin
          if (col_acc) begin
            col_cnt <= cnt_inc;
            if (cnt_inc == CW'(K)) begin
              col_ready <= 1'b0;
              win_valid <= 1'b1;
              win_last  <= last_next;
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            if (!win_last) begin
              skip_cnt  <= stride;
              col_ready <= 1'b1;
              state     <= SLIDE;
            end else if (col_cnt == img_w) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              col_ready <= 1'b1;
              state     <= DRAIN;
            end
          end
        end
        SLIDE: begin
          if (col_acc) begin
            col_cnt  <= cnt_inc;
            skip_cnt <= skip_cnt - STRIDE_W'(1);
            if (skip_cnt == STRIDE_W'(1)) begin
              col_ready <= 1'b0;
              win_valid <= 1'b1;
              win_last  <= last_next;
              state     <= EMIT;
            end
          end
        end
        DRAIN: begin
          // Tail columns are consumed so the fetch stage stays aligned, but form no window.
          if (col_acc) begin
            col_cnt <= cnt_inc;
            if (cnt_inc == img_w) begin
              col_ready <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: begin
          col_ready <= 1'b0;
          win_valid <= 1'b0;
          win_last  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
